// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
// Scans five analog channels through an external mux, averages 2^OSR_LOG2
// conversions per channel and publishes all five averages as one coherent snapshot.
module adc_scan_sequencer #(
    parameter int ADC_W        = 12,
    parameter int OSR_LOG2     = 2,
    parameter int SETTLE_CYC   = 4,
    parameter int CONV_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             clear_fault,
    output logic [2:0]       adc_ch_sel,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] cell_1_voltage_adc,
    output logic [ADC_W-1:0] cell_2_voltage_adc,
    output logic [ADC_W-1:0] cell_3_voltage_adc,
    output logic [ADC_W-1:0] pack_current_adc,
    output logic [ADC_W-1:0] temperature_adc,
    output logic             scan_valid,
    output logic             scan_busy,
    output logic             adc_timeout_fault
);

    localparam int ACC_W = ADC_W + OSR_LOG2;
    localparam int CNT_W = OSR_LOG2 + 1;
    localparam int TMAX  = (CONV_TIMEOUT > SETTLE_CYC) ? CONV_TIMEOUT : SETTLE_CYC;
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [CNT_W-1:0] SAMPLES      = CNT_W'(1 << OSR_LOG2);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(CONV_TIMEOUT - 1);
    localparam logic [2:0]       LAST_CH      = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        PUBLISH,
        FAULT
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic [ADC_W-1:0] shadow [0:3];

    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_next;
    logic [ADC_W-1:0] avg;

    assign acc_sum  = acc + ACC_W'(adc_data);
    assign cnt_next = cnt + CNT_ONE;
    assign avg      = ADC_W'(acc_sum >> OSR_LOG2);

    // The last channel's average bypasses the shadow so the whole snapshot
    // lands on the outputs on the same edge that raises scan_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            adc_ch_sel         <= '0;
            adc_start          <= 1'b0;
            acc                <= '0;
            cnt                <= '0;
            timer              <= '0;
            shadow[0]          <= '0;
            shadow[1]          <= '0;
            shadow[2]          <= '0;
            shadow[3]          <= '0;
            cell_1_voltage_adc <= '0;
            cell_2_voltage_adc <= '0;
            cell_3_voltage_adc <= '0;
            pack_current_adc   <= '0;
            temperature_adc    <= '0;
            scan_valid         <= 1'b0;
            scan_busy          <= 1'b0;
            adc_timeout_fault  <= 1'b0;
        end else begin
            adc_start  <= 1'b0;
            scan_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        adc_ch_sel <= '0;
                        timer      <= '0;
                        scan_busy  <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        timer     <= '0;
                        adc_start <= 1'b1;
                        state     <= START;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                START: begin
                    timer <= '0;
                    state <= WAIT;
                end

                // A done pulse takes priority over the timeout on the same cycle.
                WAIT: begin
                    timer <= timer + TMR_ONE;
                    if (adc_done) begin
                        if (cnt_next == SAMPLES) begin
                            acc   <= '0;
                            cnt   <= '0;
                            timer <= '0;
                            if (adc_ch_sel == LAST_CH) begin
                                cell_1_voltage_adc <= shadow[0];
                                cell_2_voltage_adc <= shadow[1];
                                cell_3_voltage_adc <= shadow[2];
                                pack_current_adc   <= shadow[3];
                                temperature_adc    <= avg;
                                scan_valid         <= 1'b1;
                                state              <= PUBLISH;
                            end else begin
                                shadow[adc_ch_sel[1:0]] <= avg;
                                adc_ch_sel              <= adc_ch_sel + 3'd1;
                                state                   <= SETTLE;
                            end
                        end else begin
                            acc       <= acc_sum;
                            cnt       <= cnt_next;
                            adc_start <= 1'b1;
                            state     <= START;
                        end
                    end else if (timer == TIMEOUT_LAST) begin
                        adc_timeout_fault <= 1'b1;
                        scan_busy         <= 1'b0;
                        state             <= FAULT;
                    end
                end

                PUBLISH: begin
                    if (scan_en) begin
                        adc_ch_sel <= '0;
                        timer      <= '0;
                        state      <= SETTLE;
                    end else begin
                        scan_busy <= 1'b0;
                        state     <= IDLE;
                    end
                end

                FAULT: begin
                    if (clear_fault) begin
                        adc_timeout_fault <= 1'b0;
                        acc               <= '0;
                        cnt               <= '0;
                        timer             <= '0;
                        adc_ch_sel        <= '0;
                        state             <= IDLE;
                    end
                end

                default: begin
                    scan_busy <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for adc_scan_sequencer: a behavioural ADC answers each start,
// expected snapshots are queued by the directed tests and popped on scan_valid.
module tb_adc_scan_sequencer;

    localparam int ADC_W = 12;
    typedef logic [4:0][ADC_W-1:0] scan_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             scan_en;
    logic             clear_fault;
    logic [2:0]       adc_ch_sel;
    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic [ADC_W-1:0] cell_1_voltage_adc;
    logic [ADC_W-1:0] cell_2_voltage_adc;
    logic [ADC_W-1:0] cell_3_voltage_adc;
    logic [ADC_W-1:0] pack_current_adc;
    logic [ADC_W-1:0] temperature_adc;
    logic             scan_valid;
    logic             scan_busy;
    logic             adc_timeout_fault;

    int n_cmp  = 0;
    int n_fail = 0;

    scan_t            exp_q[$];
    logic [ADC_W-1:0] samp [0:4][0:3];
    int               ch_log[$];
    int               resp_k        = 3;
    int               mute_ch       = -1;
    bit               resp_spurious = 1'b0;
    int               last_ch       = 7;
    int               sidx          = 0;
    int               r_ch;
    int               r_idx;

    adc_scan_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .scan_en            (scan_en),
        .clear_fault        (clear_fault),
        .adc_ch_sel         (adc_ch_sel),
        .adc_start          (adc_start),
        .adc_done           (adc_done),
        .adc_data           (adc_data),
        .cell_1_voltage_adc (cell_1_voltage_adc),
        .cell_2_voltage_adc (cell_2_voltage_adc),
        .cell_3_voltage_adc (cell_3_voltage_adc),
        .pack_current_adc   (pack_current_adc),
        .temperature_adc    (temperature_adc),
        .scan_valid         (scan_valid),
        .scan_busy          (scan_busy),
        .adc_timeout_fault  (adc_timeout_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic scan_t mk_scan(input logic [ADC_W-1:0] c1, input logic [ADC_W-1:0] c2,
                                      input logic [ADC_W-1:0] c3, input logic [ADC_W-1:0] cur,
                                      input logic [ADC_W-1:0] tmp);
        return {tmp, cur, c3, c2, c1};
    endfunction

    task automatic set_chan(input int c, input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b,
                            input logic [ADC_W-1:0] d, input logic [ADC_W-1:0] e);
        samp[c][0] = a;
        samp[c][1] = b;
        samp[c][2] = d;
        samp[c][3] = e;
    endtask

    task automatic check_words(input string tag, input scan_t e);
        checkOutput({tag, "_cell1"},   32'(cell_1_voltage_adc), 32'(e[0]));
        checkOutput({tag, "_cell2"},   32'(cell_2_voltage_adc), 32'(e[1]));
        checkOutput({tag, "_cell3"},   32'(cell_3_voltage_adc), 32'(e[2]));
        checkOutput({tag, "_current"}, 32'(pack_current_adc),   32'(e[3]));
        checkOutput({tag, "_temp"},    32'(temperature_adc),    32'(e[4]));
    endtask

    // Starts a scan (one-cycle pulse or held level) and counts cycles to scan_valid.
    task automatic applyStimulus(input bit hold, input int limit, output int cycles);
        last_ch = 7;
        ch_log.delete();
        @(negedge clk);
        scan_en = 1'b1;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!hold) scan_en = 1'b0;
        end while (scan_valid !== 1'b1 && cycles < limit);
    endtask

    task automatic table_t1();
        set_chan(0, 12'd10, 12'd20, 12'd30, 12'd40);
        set_chan(1, 12'd100, 12'd101, 12'd102, 12'd104);
        set_chan(2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        set_chan(3, 12'd1, 12'd2, 12'd2, 12'd2);
        set_chan(4, 12'h800, 12'h801, 12'h7FF, 12'h7FE);
    endtask

    task automatic table_t2();
        set_chan(0, 12'd1000, 12'd1000, 12'd1001, 12'd1001);
        set_chan(1, 12'd0, 12'd0, 12'd0, 12'd3);
        set_chan(2, 12'd7, 12'd8, 12'd9, 12'd10);
        set_chan(3, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF);
        set_chan(4, 12'd300, 12'd301, 12'd302, 12'd303);
    endtask

    task automatic table_t3();
        set_chan(0, 12'd5, 12'd5, 12'd5, 12'd5);
        set_chan(1, 12'd6, 12'd7, 12'd6, 12'd7);
        set_chan(2, 12'h100, 12'h200, 12'h300, 12'h400);
        set_chan(3, 12'd0, 12'd1, 12'd0, 12'd1);
        set_chan(4, 12'd50, 12'd60, 12'd70, 12'd80);
    endtask

    // Behavioural ADC: answers each start after resp_k WAIT cycles.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (adc_start === 1'b1) begin
                r_ch = int'(adc_ch_sel);
                ch_log.push_back(r_ch);
                if (r_ch != last_ch) sidx = 0;
                last_ch = r_ch;
                r_idx   = sidx;
                sidx    = (sidx + 1) % 4;
                if (r_ch != mute_ch && r_ch < 5) begin
                    repeat (resp_k) @(negedge clk);
                    adc_done = 1'b1;
                    adc_data = samp[r_ch][r_idx];
                    if (resp_spurious && r_idx == 3) begin
                        @(negedge clk);
                        adc_done = 1'b0;
                        @(negedge clk);
                        adc_done = 1'b1;
                        adc_data = 12'hABC;
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        scan_t e;
        forever begin
            @(negedge clk);
            if (scan_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_scan_valid", 32'(scan_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_words("sb", e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   cyc;
        int   bad;
        scan_t t1_exp;
        scan_t t2_exp;
        scan_t t3_exp;
        t1_exp = mk_scan(12'd25, 12'd101, 12'hFFF, 12'd1, 12'h7FF);
        t2_exp = mk_scan(12'd1000, 12'd0, 12'd8, 12'hFFE, 12'd301);
        t3_exp = mk_scan(12'd5, 12'd6, 12'h280, 12'd0, 12'd65);

        rst         = 1'b1;
        scan_en     = 1'b0;
        clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        check_words("reset", mk_scan(12'd0, 12'd0, 12'd0, 12'd0, 12'd0));
        checkOutput("reset_valid", 32'(scan_valid), 32'd0);
        checkOutput("reset_busy", 32'(scan_busy), 32'd0);
        checkOutput("reset_fault", 32'(adc_timeout_fault), 32'd0);
        checkOutput("reset_start", 32'(adc_start), 32'd0);
        checkOutput("reset_ch_sel", 32'(adc_ch_sel), 32'd0);
        rst = 1'b0;

        $display("[TB] single scan, k=3");
        table_t1();
        resp_k = 3;
        exp_q.push_back(t1_exp);
        applyStimulus(1'b0, 300, cyc);
        checkOutput("single_scan_latency", 32'(cyc), 32'd101);
        checkOutput("start_count", 32'(ch_log.size()), 32'd20);
        bad = 0;
        foreach (ch_log[i]) if (ch_log[i] != i / 4) bad++;
        checkOutput("ch_sel_sequence_errors", 32'(bad), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("busy_after_single", 32'(scan_busy), 32'd0);

        $display("[TB] continuous scans, stop during channel 1");
        table_t2();
        exp_q.push_back(t2_exp);
        exp_q.push_back(t2_exp);
        applyStimulus(1'b1, 300, cyc);
        checkOutput("cont_first_latency", 32'(cyc), 32'd101);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (scan_en && adc_ch_sel == 3'd1) scan_en = 1'b0;
        end while (scan_valid !== 1'b1 && cyc < 300);
        checkOutput("cont_period", 32'(cyc), 32'd101);
        checkOutput("scan_en_dropped", 32'(scan_en), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("busy_after_stop", 32'(scan_busy), 32'd0);

        $display("[TB] spurious done during settle, k=1");
        table_t3();
        resp_k        = 1;
        resp_spurious = 1'b1;
        exp_q.push_back(t3_exp);
        applyStimulus(1'b0, 300, cyc);
        checkOutput("spurious_latency", 32'(cyc), 32'd61);
        repeat (4) @(negedge clk);
        resp_spurious = 1'b0;
        check_words("spurious_hold", t3_exp);

        $display("[TB] done on the timeout cycle, k=255");
        table_t1();
        resp_k = 255;
        exp_q.push_back(t1_exp);
        applyStimulus(1'b0, 6000, cyc);
        checkOutput("boundary_latency", 32'(cyc), 32'd5141);
        checkOutput("boundary_no_fault", 32'(adc_timeout_fault), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] ADC silent on channel 3");
        table_t2();
        resp_k  = 3;
        mute_ch = 3;
        last_ch = 7;
        @(negedge clk);
        scan_en = 1'b1;
        @(negedge clk);
        scan_en = 1'b0;
        cyc = 0;
        while (!(adc_start === 1'b1 && adc_ch_sel == 3'd3) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ch3_start", {28'd0, adc_start, adc_ch_sel}, 32'hB);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (adc_timeout_fault !== 1'b1 && cyc < 400);
        checkOutput("timeout_cycles", 32'(cyc), 32'd256);
        check_words("fault_hold", t1_exp);
        checkOutput("fault_busy", 32'(scan_busy), 32'd0);
        scan_en = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("fault_ignores_scan_en_busy", 32'(scan_busy), 32'd0);
        checkOutput("fault_no_start", 32'(adc_start), 32'd0);
        checkOutput("fault_sticky", 32'(adc_timeout_fault), 32'd1);
        scan_en = 1'b0;
        @(negedge clk);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        checkOutput("clear_fault_flag", 32'(adc_timeout_fault), 32'd0);
        checkOutput("clear_fault_busy", 32'(scan_busy), 32'd0);
        checkOutput("clear_fault_ch_sel", 32'(adc_ch_sel), 32'd0);

        $display("[TB] recovery scan after fault");
        mute_ch = -1;
        table_t3();
        exp_q.push_back(t3_exp);
        applyStimulus(1'b0, 300, cyc);
        checkOutput("recovery_latency", 32'(cyc), 32'd101);
        repeat (3) @(negedge clk);

        $display("[TB] reset during WAIT");
        table_t1();
        resp_k  = 10;
        last_ch = 7;
        @(negedge clk);
        scan_en = 1'b1;
        @(negedge clk);
        scan_en = 1'b0;
        cyc = 0;
        while (!(adc_start === 1'b1 && adc_ch_sel == 3'd2) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ch2_start", {28'd0, adc_start, adc_ch_sel}, 32'hA);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_words("midreset", mk_scan(12'd0, 12'd0, 12'd0, 12'd0, 12'd0));
        checkOutput("midreset_busy", 32'(scan_busy), 32'd0);
        checkOutput("midreset_ch_sel", 32'(adc_ch_sel), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("late_done_busy", 32'(scan_busy), 32'd0);
        checkOutput("late_done_start", 32'(adc_start), 32'd0);
        checkOutput("late_done_fault", 32'(adc_timeout_fault), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
